// File: rtl/pe_conv_row.sv
// K-tap 1-D convolution processing element: streamed samples slide through a
// window of K signed weights; saturated partial sums go downstream over valid/ready.
module pe_conv_row #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ready,
    input  logic              reload,
    input  logic              stride2,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int PW = 2 * DATA_W;
    localparam int SW = ACC_W + 1;
    localparam int CW = $clog2(K);
    localparam logic [CW-1:0]    LAST_IDX = CW'(K - 1);
    localparam logic [ACC_W-1:0] SAT_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t state, state_next;

    logic signed [DATA_W-1:0] w_reg [K];
    logic signed [DATA_W-1:0] win   [K-1];
    logic [CW-1:0]            w_cnt;
    logic [CW-1:0]            fill;
    logic                     phase;
    logic                     stride_r;
    logic                     reload_pend;

    logic en, in_acc, w_acc, handoff, full, stride_eff, emit;

    logic signed [DATA_W-1:0] tap  [K];
    logic signed [PW-1:0]     prod [K];

    logic                     s1_valid;
    logic                     s1_pass;
    logic                     s1_last;
    logic signed [PW-1:0]     s1_prod [K];
    logic signed [ACC_W-1:0]  s1_psum;
    logic signed [SW-1:0]     sum;
    logic [ACC_W-1:0]         sat;

    assign en         = !(out_valid && !out_ready);
    assign in_acc     = in_valid && in_ready;
    assign w_acc      = w_valid && w_ready;
    assign handoff    = out_valid && out_ready && out_last;
    assign full       = (fill == LAST_IDX);
    // stride is captured on the first sample of a frame; before that use the live input
    assign stride_eff = (fill == '0) ? stride2 : stride_r;
    assign emit       = full && !(stride_eff && phase);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        w_ready    = 1'b0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                w_ready = 1'b1;
                if (w_acc) state_next = LOAD;
            end
            LOAD: begin
                w_ready = 1'b1;
                if (w_acc && w_cnt == LAST_IDX) state_next = RUN;
            end
            RUN: begin
                in_ready = en;
                if (in_acc && in_last) state_next = DRAIN;
            end
            DRAIN: begin
                if (handoff) state_next = (reload_pend || reload) ? IDLE : RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < K; k++) w_reg[k] <= '0;
            w_cnt       <= '0;
            reload_pend <= 1'b0;
        end else begin
            if (w_acc) begin
                w_reg[w_cnt] <= $signed(w_data);
                w_cnt        <= (w_cnt == LAST_IDX) ? '0 : w_cnt + 1'b1;
            end
            if (state == IDLE || state == LOAD || (state == DRAIN && handoff)) begin
                reload_pend <= 1'b0;
            end else if (reload) begin
                reload_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < K - 1; k++) tap[k] = win[k];
        tap[K-1] = $signed(in_data);
        for (int unsigned k = 0; k < K; k++) prod[k] = PW'(tap[k]) * PW'(w_reg[k]);
    end

    always_comb begin
        sum = SW'(s1_psum);
        for (int unsigned k = 0; k < K; k++) sum = sum + SW'(s1_prod[k]);
        if (sum[SW-1] != sum[SW-2]) begin
            sat = sum[SW-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sat = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < K - 1; k++) win[k] <= '0;
            for (int unsigned k = 0; k < K; k++) s1_prod[k] <= '0;
            fill      <= '0;
            phase     <= 1'b0;
            stride_r  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_pass   <= 1'b0;
            s1_last   <= 1'b0;
            s1_psum   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (en) begin
            if (in_acc) begin
                for (int unsigned k = 0; k + 1 < K - 1; k++) win[k] <= win[k+1];
                win[K-2] <= $signed(in_data);
                if (fill == '0) stride_r <= stride2;
                if (in_last) begin
                    // frame end overrides the shift: next frame starts with an empty window
                    for (int unsigned k = 0; k < K - 1; k++) win[k] <= '0;
                    fill  <= '0;
                    phase <= 1'b0;
                end else begin
                    if (!full) fill <= fill + 1'b1;
                    if (full) phase <= !phase;
                end
            end
            s1_valid <= in_acc && (emit || in_last);
            s1_pass  <= !emit;
            s1_last  <= in_last;
            s1_prod  <= prod;
            s1_psum  <= $signed(psum_in);

            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_pass ? s1_psum : sat;
                out_last <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_pe_conv_row.sv
// Directed bench for pe_conv_row (DATA_W=8, K=3, ACC_W=20) with hand-computed results.
module tb_pe_conv_row;

    localparam int DW = 8;
    localparam int KK = 3;
    localparam int AW = 20;

    logic          clk;
    logic          reset_n;
    logic          w_valid;
    logic [DW-1:0] w_data;
    logic          w_ready;
    logic          reload;
    logic          stride2;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [AW-1:0] psum_in;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    pe_conv_row #(.DATA_W(DW), .K(KK), .ACC_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .reload(reload), .stride2(stride2),
        .in_valid(in_valid), .in_data(in_data), .psum_in(psum_in), .in_last(in_last),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] q_data [$];
    logic          q_last [$];
    int            q_cyc  [$];

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
    end

    int errors = 0;
    int checks = 0;
    int acc_cyc [8];

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 1'b0; w_valid = 1'b0; reload = 1'b0;
        stride2 = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic load_weights(input int a, input int b, input int c);
        int ws [3];
        bit ok;
        ws = '{a, b, c};
        for (int i = 0; i < 3; i++) begin
            ok = 0;
            w_valid = 1'b1;
            w_data  = DW'(ws[i]);
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                if (w_ready) ok = 1;
                @(posedge clk); #1;
            end
            w_valid = 1'b0;
            if (!ok) begin
                errors++; checks++;
                $display("FAIL load_timeout beat=%0d w_ready=0 required=1", i);
            end
        end
    endtask

    task automatic send_sample(input int x, input int p, input logic last, input int idx);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = DW'(x);
        psum_in  = AW'(p);
        in_last  = last;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                acc_cyc[idx] = cyc;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            errors++; checks++;
            $display("FAIL send_timeout sample=%0d in_ready=0 required=1", idx);
        end
    endtask

    task automatic send_frame(input int xs [8], input int n, input int p, input logic s2);
        stride2 = s2;
        for (int i = 0; i < n; i++) send_sample(xs[i], p, (i == n - 1), i);
        stride2 = 1'b0;
    endtask

    task automatic wait_last(input int base);
        bit ok;
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk); #1;
            if (q_last.size() > base && q_last[q_last.size()-1]) ok = 1;
        end
        @(posedge clk); #1;
        if (!ok) begin
            errors++; checks++;
            $display("FAIL frame_timeout out_last never seen");
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (w_ready !== 1'b1)   begin errors++; $display("FAIL rst_w_ready got=%b exp=1", w_ready); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0)    begin errors++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        checks++; if (w_ready !== 1'b1)  begin errors++; $display("FAIL idle_w_ready got=%b exp=1", w_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_stride1();
        int base; int xs [8]; int ex [3];
        logic [AW-1:0] got;
        base = q_data.size();
        load_weights(1, 2, 3);
        xs = '{1, 2, 3, 4, 5, 0, 0, 0};
        ex = '{14, 20, 26};
        send_frame(xs, 5, 0, 1'b0);
        wait_last(base);
        checks++; if (q_data.size() - base !== 3) begin errors++; $display("FAIL s1_count got=%0d exp=3", q_data.size() - base); end
        for (int i = 0; i < 3; i++) begin
            got = (base + i < q_data.size()) ? q_data[base+i] : '1;
            checks++; if (got !== AW'(ex[i])) begin errors++; $display("FAIL s1_data[%0d] got=%0d exp=%0d", i, $signed(got), ex[i]); end
            checks++; if ((base + i < q_last.size() && q_last[base+i]) !== (i == 2)) begin errors++; $display("FAIL s1_last[%0d] exp=%0d", i, i == 2); end
        end
        checks++; if (q_cyc[base] - acc_cyc[2] !== 2) begin errors++; $display("FAIL s1_latency got=%0d exp=2", q_cyc[base] - acc_cyc[2]); end
        checks++; if (w_ready !== 1'b0)  begin errors++; $display("FAIL run_w_ready got=%b exp=0", w_ready); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_stride2();
        int base; int xs [8]; int ex [2];
        logic [AW-1:0] got;
        base = q_data.size();
        xs = '{1, 2, 3, 4, 5, 0, 0, 0};
        ex = '{14, 26};
        send_frame(xs, 5, 0, 1'b1);
        wait_last(base);
        checks++; if (q_data.size() - base !== 2) begin errors++; $display("FAIL s2_count got=%0d exp=2", q_data.size() - base); end
        for (int i = 0; i < 2; i++) begin
            got = (base + i < q_data.size()) ? q_data[base+i] : '1;
            checks++; if (got !== AW'(ex[i])) begin errors++; $display("FAIL s2_data[%0d] got=%0d exp=%0d", i, $signed(got), ex[i]); end
            checks++; if ((base + i < q_last.size() && q_last[base+i]) !== (i == 1)) begin errors++; $display("FAIL s2_last[%0d] exp=%0d", i, i == 1); end
        end
        // back to stride 1 on the next frame
        base = q_data.size();
        xs = '{1, 2, 3, 4, 0, 0, 0, 0};
        ex = '{14, 20};
        send_frame(xs, 4, 0, 1'b0);
        wait_last(base);
        checks++; if (q_data.size() - base !== 2) begin errors++; $display("FAIL s2b_count got=%0d exp=2", q_data.size() - base); end
        for (int i = 0; i < 2; i++) begin
            got = (base + i < q_data.size()) ? q_data[base+i] : '1;
            checks++; if (got !== AW'(ex[i])) begin errors++; $display("FAIL s2b_data[%0d] got=%0d exp=%0d", i, $signed(got), ex[i]); end
        end
    endtask

    task automatic test_backpressure();
        int base; int xs [8]; int ex [5];
        logic [AW-1:0] got;
        logic [AW-1:0] held;
        bit seen;
        base = q_data.size();
        xs = '{1, 2, 3, 4, 5, 6, 7, 0};
        ex = '{14, 20, 26, 32, 38};
        fork
            send_frame(xs, 7, 0, 1'b0);
            begin
                seen = 0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk); #1;
                    if (out_valid) seen = 1;
                end
                if (!seen) begin errors++; checks++; $display("FAIL bp_timeout out_valid=0 exp=1"); end
                @(posedge clk); #1 out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                checks++; if (held !== AW'(20)) begin errors++; $display("FAIL bp_held got=%0d exp=20", held); end
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
                    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
                    checks++; if (out_data !== held)  begin errors++; $display("FAIL bp_frozen[%0d] got=%0d exp=%0d", i, out_data, held); end
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        wait_last(base);
        checks++; if (q_data.size() - base !== 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", q_data.size() - base); end
        for (int i = 0; i < 5; i++) begin
            got = (base + i < q_data.size()) ? q_data[base+i] : '1;
            checks++; if (got !== AW'(ex[i])) begin errors++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, $signed(got), ex[i]); end
        end
    endtask

    task automatic test_short_frame();
        int base; int xs [8];
        base = q_data.size();
        send_sample(5, 100, 1'b0, 0);
        send_sample(6, -7, 1'b1, 1);
        wait_last(base);
        checks++; if (q_data.size() - base !== 1) begin errors++; $display("FAIL short_count got=%0d exp=1", q_data.size() - base); end
        checks++; if (q_data[base] !== AW'(-7)) begin errors++; $display("FAIL short_data got=%0d exp=-7", $signed(q_data[base])); end
        checks++; if (q_last[base] !== 1'b1) begin errors++; $display("FAIL short_last got=%b exp=1", q_last[base]); end
        // window must start empty again; psum now adds in
        base = q_data.size();
        xs = '{1, 2, 3, 0, 0, 0, 0, 0};
        send_frame(xs, 3, 1000, 1'b0);
        wait_last(base);
        checks++; if (q_data.size() - base !== 1) begin errors++; $display("FAIL after_short_count got=%0d exp=1", q_data.size() - base); end
        checks++; if (q_data[base] !== AW'(1014)) begin errors++; $display("FAIL after_short_data got=%0d exp=1014", $signed(q_data[base])); end
    endtask

    task automatic test_reload();
        int base; int xs [8]; int ex [3];
        logic [AW-1:0] got;
        base = q_data.size();
        ex = '{14, 20, 26};
        send_sample(1, 0, 1'b0, 0);
        reload = 1'b1;
        send_sample(2, 0, 1'b0, 1);
        reload = 1'b0;
        send_sample(3, 0, 1'b0, 2);
        send_sample(4, 0, 1'b0, 3);
        send_sample(5, 0, 1'b1, 4);
        wait_last(base);
        checks++; if (q_data.size() - base !== 3) begin errors++; $display("FAIL rl_count got=%0d exp=3", q_data.size() - base); end
        for (int i = 0; i < 3; i++) begin
            got = (base + i < q_data.size()) ? q_data[base+i] : '1;
            checks++; if (got !== AW'(ex[i])) begin errors++; $display("FAIL rl_data[%0d] got=%0d exp=%0d", i, $signed(got), ex[i]); end
        end
        checks++; if (w_ready !== 1'b1)  begin errors++; $display("FAIL rl_w_ready got=%b exp=1", w_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rl_in_ready got=%b exp=0", in_ready); end
        load_weights(0, 0, 1);
        base = q_data.size();
        xs = '{9, -4, 7, 3, 0, 0, 0, 0};
        send_frame(xs, 4, 0, 1'b0);
        wait_last(base);
        checks++; if (q_data.size() - base !== 2) begin errors++; $display("FAIL id_count got=%0d exp=2", q_data.size() - base); end
        got = (base < q_data.size()) ? q_data[base] : '1;
        checks++; if (got !== AW'(7)) begin errors++; $display("FAIL id_data[0] got=%0d exp=7", $signed(got)); end
        got = (base + 1 < q_data.size()) ? q_data[base+1] : '1;
        checks++; if (got !== AW'(3)) begin errors++; $display("FAIL id_data[1] got=%0d exp=3", $signed(got)); end
        checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL id_w_ready got=%b exp=0", w_ready); end
    endtask

    task automatic test_saturation();
        int base; int xs [8]; int ps [4]; int xv [4]; int ex [4];
        do_reset();
        load_weights(-128, -128, -128);
        xv = '{-128, -128, 127, 127};
        ps = '{524287, 475134, -524288, -475519};
        ex = '{524287, 524286, -524288, -524287};
        for (int c = 0; c < 4; c++) begin
            base = q_data.size();
            xs = '{xv[c], xv[c], xv[c], 0, 0, 0, 0, 0};
            send_frame(xs, 3, ps[c], 1'b0);
            wait_last(base);
            checks++; if (q_data.size() - base !== 1) begin errors++; $display("FAIL sat_count[%0d] got=%0d exp=1", c, q_data.size() - base); end
            checks++; if (q_data[base] !== AW'(ex[c])) begin errors++; $display("FAIL sat_data[%0d] got=%0d exp=%0d", c, $signed(q_data[base]), ex[c]); end
        end
    endtask

    task automatic test_async_reset();
        int base; int xs [8];
        do_reset();
        load_weights(1, 2, 3);
        for (int v = 1; v <= 4; v++) begin
            in_valid = 1'b1; in_data = DW'(v); psum_in = '0; in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got=%b exp=1", out_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0)    begin errors++; $display("FAIL ar_out_data got=%0d exp=0", out_data); end
        checks++; if (w_ready !== 1'b1)   begin errors++; $display("FAIL ar_w_ready got=%b exp=1", w_ready); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL ar_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_edge_valid got=%b exp=0", out_valid); end
        reset_n = 1'b1;
        load_weights(1, 2, 3);
        base = q_data.size();
        xs = '{1, 2, 3, 0, 0, 0, 0, 0};
        send_frame(xs, 3, 0, 1'b0);
        wait_last(base);
        checks++; if (q_data.size() - base !== 1) begin errors++; $display("FAIL ar_post_count got=%0d exp=1", q_data.size() - base); end
        checks++; if (q_data[base] !== AW'(14)) begin errors++; $display("FAIL ar_post_data got=%0d exp=14", $signed(q_data[base])); end
    endtask

    initial begin
        reset_n = 1'b0; w_valid = 1'b0; w_data = '0; reload = 1'b0; stride2 = 1'b0;
        in_valid = 1'b0; in_data = '0; psum_in = '0; in_last = 1'b0; out_ready = 1'b1;
        test_reset();
        test_stride1();
        test_stride2();
        test_backpressure();
        test_short_frame();
        test_reload();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
